// File: rtl/sr_mem_arbiter.sv
// sr_mem_arbiter: two-requester arbiter in front of a single-port data RAM.
// Requester 0 is the core and requester 1 is the loader/debug port. Requests
// that arrive together are served in round-robin order. A requester can set
// lock to keep ownership across several back-to-back accesses. Illegal
// accesses are still granted and complete with an error response. They
// never reach the RAM.
//
// Handshake: a requester raises mX_req with all fields stable and holds them
// until mX_gnt is high in the same cycle. The access completes at that clock
// edge. mX_rvalid (with mX_err / mX_rdata) pulses for exactly one cycle
// afterwards. Nothing is latched, so a request dropped before its grant is
// simply forgotten. Back-to-back grants give back-to-back rvalid pulses.
module sr_mem_arbiter #(
  parameter int unsigned DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_we,
  input  logic [1:0]  m0_size,
  input  logic        m0_sign,
  input  logic        m0_lock,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_we,
  input  logic [1:0]  m1_size,
  input  logic        m1_sign,
  input  logic        m1_lock,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_sign,
  output logic        mem_op_word,
  output logic        mem_op_half,
  output logic        mem_op_byte,
  input  logic [31:0] mem_rdata
);

  // The last three bytes are excluded so that a word access never runs off the RAM.
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH - 3);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t      state_q;
  logic        rr_q;        // requester favoured when both ask in IDLE

  logic [31:0] g_addr;
  logic [31:0] g_wdata;
  logic        g_we;
  logic [1:0]  g_size;
  logic        g_sign;
  logic        g_illegal;
  logic        access_ok;

  // Grant decision: ownership first, then single request, then round-robin.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_req && m1_req) begin
          m0_gnt = ~rr_q;
          m1_gnt = rr_q;
        end else begin
          m0_gnt = m0_req;
          m1_gnt = m1_req;
        end
      end
      OWN0:    m0_gnt = m0_req;
      OWN1:    m1_gnt = m1_req;
      default: ;
    endcase
    // No grant is visible while reset is held.
    m0_gnt = m0_gnt & rst_n;
    m1_gnt = m1_gnt & rst_n;
  end

  // Route the granted requester's fields and classify the access.
  always_comb begin
    if (m1_gnt) begin
      g_addr  = m1_addr;
      g_wdata = m1_wdata;
      g_we    = m1_we;
      g_size  = m1_size;
      g_sign  = m1_sign;
    end else begin
      g_addr  = m0_addr;
      g_wdata = m0_wdata;
      g_we    = m0_we;
      g_size  = m0_size;
      g_sign  = m0_sign;
    end
    g_illegal = (g_size == 2'b11) ||
                ((g_size == 2'b01) && g_addr[0]) ||
                ((g_size == 2'b10) && (g_addr[1:0] != 2'b00)) ||
                (g_addr >= ADDR_LIMIT);
    access_ok = (m0_gnt | m1_gnt) & ~g_illegal;
  end

  // RAM-side drive. The controls are qualified so that an idle or illegal
  // cycle leaves the RAM alone.
  always_comb begin
    mem_addr    = g_addr;
    mem_wdata   = g_wdata;
    mem_sign    = g_sign;
    mem_we      = access_ok & g_we;
    mem_op_byte = access_ok & (g_size == 2'b00);
    mem_op_half = access_ok & (g_size == 2'b01);
    mem_op_word = access_ok & (g_size == 2'b10);
  end

  // Ownership FSM and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_gnt) begin
            if (m0_lock) state_q <= OWN0;
            else         rr_q    <= 1'b1;
          end else if (m1_gnt) begin
            if (m1_lock) state_q <= OWN1;
            else         rr_q    <= 1'b0;
          end
        end
        OWN0: begin
          if (!m0_req || !m0_lock) begin
            state_q <= IDLE;
            rr_q    <= 1'b1;
          end
        end
        OWN1: begin
          if (!m1_req || !m1_lock) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Responses are registered one cycle after the grant. Error responses
  // clear rdata, loads capture RAM data, and stores leave rdata untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rvalid <= 1'b0;
      m0_err    <= 1'b0;
      m0_rdata  <= '0;
      m1_rvalid <= 1'b0;
      m1_err    <= 1'b0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= m0_gnt;
      m0_err    <= m0_gnt & g_illegal;
      m1_rvalid <= m1_gnt;
      m1_err    <= m1_gnt & g_illegal;
      if (m0_gnt) begin
        if (g_illegal)  m0_rdata <= '0;
        else if (!g_we) m0_rdata <= mem_rdata;
      end
      if (m1_gnt) begin
        if (g_illegal)  m1_rdata <= '0;
        else if (!g_we) m1_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_sr_mem_arbiter.sv
// tb_sr_mem_arbiter: directed bench for sr_mem_arbiter with a byte RAM device,
// a transaction-level reference model and an expected-response queue.
module tb_sr_mem_arbiter;

  localparam int DEPTH = 256;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m0_we, m0_sign, m0_lock, m0_gnt, m0_rvalid, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [1:0]  m0_size;
  logic        m1_req, m1_we, m1_sign, m1_lock, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [1:0]  m1_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_sign, mem_op_word, mem_op_half, mem_op_byte;

  sr_mem_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
    .m0_size(m0_size), .m0_sign(m0_sign), .m0_lock(m0_lock), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
    .m1_size(m1_size), .m1_sign(m1_sign), .m1_lock(m1_lock), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_sign(mem_sign),
    .mem_op_word(mem_op_word), .mem_op_half(mem_op_half), .mem_op_byte(mem_op_byte),
    .mem_rdata(mem_rdata)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] init_byte(input int i);
    return 8'(i * 37 + 5);
  endfunction

  // ---------------- RAM device (combinational read) ----------------
  logic [7:0] ram [DEPTH];
  logic [7:0] ram_a;
  logic       ram_load;
  assign ram_a = mem_addr[7:0];

  always_comb begin
    mem_rdata = '0;
    if (mem_op_word)
      mem_rdata = {ram[ram_a + 8'd3], ram[ram_a + 8'd2], ram[ram_a + 8'd1], ram[ram_a]};
    else if (mem_op_half)
      mem_rdata = {{16{mem_sign & ram[ram_a + 8'd1][7]}}, ram[ram_a + 8'd1], ram[ram_a]};
    else if (mem_op_byte)
      mem_rdata = {{24{mem_sign & ram[ram_a][7]}}, ram[ram_a]};
  end

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_byte(i);
    end else if (mem_we) begin
      ram[ram_a] <= mem_wdata[7:0];
      if (mem_op_half || mem_op_word) ram[ram_a + 8'd1] <= mem_wdata[15:8];
      if (mem_op_word) begin
        ram[ram_a + 8'd2] <= mem_wdata[23:16];
        ram[ram_a + 8'd3] <= mem_wdata[31:24];
      end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  logic [7:0]  ref_mem [DEPTH];
  logic [33:0] exp_q[$];          // {requester, err, rdata} expected next cycle
  logic [31:0] hold_rd [2];
  int          gnt_log[$];        // requester granted, in order
  int          exp_seq[$];
  bit          model_ready = 1'b0;
  int          own, rr_m, win;
  bit          has_rsp, legal;
  logic [33:0] rsp;
  logic [31:0] rd;
  logic        req_a [2], we_a [2], sign_a [2], lock_a [2];
  logic [31:0] addr_a [2], wdata_a [2];
  logic [1:0]  size_a [2];

  function automatic bit is_legal(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd3) return 1'b0;
    if (sz == 2'd1 && (a % 2) != 0) return 1'b0;
    if (sz == 2'd2 && (a % 4) != 0) return 1'b0;
    if (a >= 32'(DEPTH - 3)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int n_bytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input int a, input logic [1:0] sz, input logic sg);
    logic [31:0] v;
    int nb;
    nb = n_bytes(sz);
    v  = '0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[a + i];
    if (sg && v[8*nb-1]) for (int i = 8 * nb; i < 32; i++) v[i] = 1'b1;
    return v;
  endfunction

  always @(negedge clk) begin
    if (!model_ready) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_byte(i);
      model_ready = 1'b1;
    end
    if (!rst_n) begin
      own = -1; rr_m = 0; exp_q.delete(); hold_rd[0] = '0; hold_rd[1] = '0;
      check("rst_gnt", {m1_gnt, m0_gnt}, 0);
      check("rst_rvalid", {m1_rvalid, m0_rvalid}, 0);
      check("rst_err", {m1_err, m0_err}, 0);
      check("rst_rdata0", m0_rdata, 0);
      check("rst_rdata1", m1_rdata, 0);
      check("rst_mem_ctl", {mem_we, mem_op_word, mem_op_half, mem_op_byte}, 0);
    end else begin
      // response due from the previous edge
      has_rsp = (exp_q.size() != 0);
      rsp = '0;
      if (has_rsp) begin
        rsp = exp_q.pop_front();
        hold_rd[rsp[33]] = rsp[31:0];
      end
      check("rvalid0", m0_rvalid, has_rsp && !rsp[33]);
      check("rvalid1", m1_rvalid, has_rsp && rsp[33]);
      check("err0", m0_err, has_rsp && !rsp[33] && rsp[32]);
      check("err1", m1_err, has_rsp && rsp[33] && rsp[32]);
      check("rdata0", m0_rdata, hold_rd[0]);
      check("rdata1", m1_rdata, hold_rd[1]);

      req_a  = '{m0_req, m1_req};     addr_a = '{m0_addr, m1_addr};
      wdata_a = '{m0_wdata, m1_wdata}; we_a  = '{m0_we, m1_we};
      size_a = '{m0_size, m1_size};    sign_a = '{m0_sign, m1_sign};
      lock_a = '{m0_lock, m1_lock};

      win = -1;
      if (own < 0) begin
        if (req_a[0] && req_a[1]) win = rr_m;
        else if (req_a[0])        win = 0;
        else if (req_a[1])        win = 1;
      end else if (req_a[own]) begin
        win = own;
      end
      check("gnt0", m0_gnt, win == 0);
      check("gnt1", m1_gnt, win == 1);

      if (win >= 0) begin
        gnt_log.push_back(win);
        legal = is_legal(addr_a[win], size_a[win]);
        check("mem_addr", mem_addr, addr_a[win]);
        check("mem_wdata", mem_wdata, wdata_a[win]);
        check("mem_sign", mem_sign, sign_a[win]);
        check("mem_we", mem_we, legal && we_a[win]);
        check("mem_op", {mem_op_word, mem_op_half, mem_op_byte},
              !legal ? 3'b000 : (size_a[win] == 2'd0) ? 3'b001 :
              (size_a[win] == 2'd1) ? 3'b010 : 3'b100);
        if (!legal) rd = '0;
        else if (!we_a[win]) rd = ref_load(int'(addr_a[win]), size_a[win], sign_a[win]);
        else begin
          for (int i = 0; i < n_bytes(size_a[win]); i++)
            ref_mem[int'(addr_a[win]) + i] = wdata_a[win][8*i +: 8];
          rd = hold_rd[win];
        end
        exp_q.push_back({win[0], ~legal, rd});
      end else begin
        check("mem_idle", {mem_we, mem_op_word, mem_op_half, mem_op_byte}, 0);
      end

      if (own < 0) begin
        if (win >= 0) begin
          if (lock_a[win]) own = win;
          else             rr_m = 1 - win;
        end
      end else if (!req_a[own] || !lock_a[own]) begin
        rr_m = 1 - own;
        own  = -1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_m(input int x, input logic req, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic we, input logic [1:0] size,
                       input logic sign, input logic lock);
    if (x == 0) begin
      m0_req = req; m0_addr = addr; m0_wdata = wdata; m0_we = we;
      m0_size = size; m0_sign = sign; m0_lock = lock;
    end else begin
      m1_req = req; m1_addr = addr; m1_wdata = wdata; m1_we = we;
      m1_size = size; m1_sign = sign; m1_lock = lock;
    end
  endtask

  task automatic idle(input int x);
    set_m(x, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_log(input string name);
    check({name, "_count"}, gnt_log.size(), exp_seq.size());
    for (int i = 0; i < exp_seq.size() && i < gnt_log.size(); i++)
      check($sformatf("%s_%0d", name, i), gnt_log[i], exp_seq[i]);
  endtask

  // boundary table for requester 1 loads: address, size, expected err
  logic [31:0] bt_addr [7] = '{32'd252, 32'd253, 32'd250, 32'h11, 32'h12, 32'h0C, 32'd248};
  logic [1:0]  bt_size [7] = '{2'd0,    2'd0,    2'd1,    2'd1,  2'd2,  2'd3,  2'd2};
  logic        bt_err  [7] = '{1'b0,    1'b1,    1'b0,    1'b1,  1'b1,  1'b1,  1'b0};

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; ram_load = 1'b1;
    idle(0); idle(1);
    repeat (3) step();
    check("reset_rdata0", m0_rdata, 32'h0);
    ram_load = 1'b0; rst_n = 1'b1;
    step();

    // Both request, rr=0: word load at 0x10 wins, then the store from requester 1.
    set_m(0, 1, 32'h10, 32'h0, 0, 2'b10, 0, 0);
    set_m(1, 1, 32'h20, 32'hDEADBEEF, 1, 2'b10, 0, 0);
    gnt_log.delete();
    step();
    check("r41_m0_rvalid", m0_rvalid, 1);
    check("r41_m0_rdata", m0_rdata, 32'hC49F7A55);
    idle(0);
    step();
    check("r41_m1_rvalid", m1_rvalid, 1);
    idle(1);
    check("r41_ram", {ram[35], ram[34], ram[33], ram[32]}, 32'hDEADBEEF);
    exp_seq = '{0, 1}; check_log("r41_order");
    step();

    // Continuous unlocked contention alternates.
    set_m(0, 1, 32'h21, 32'h0, 0, 2'b00, 0, 0);
    set_m(1, 1, 32'h22, 32'h0, 0, 2'b01, 1, 0);
    gnt_log.delete();
    repeat (6) step();
    idle(0); idle(1);
    exp_seq = '{0, 1, 0, 1, 0, 1}; check_log("r42_alt");
    check("r42_m0_rdata", m0_rdata, 32'h000000BE);
    check("r42_m1_rdata", m1_rdata, 32'hFFFFDEAD);
    step();

    // Requester 1 locks for three stores while requester 0 waits.
    set_m(0, 1, 32'h0, 32'h0, 0, 2'b10, 0, 0);
    step();
    set_m(0, 1, 32'h4, 32'h0, 0, 2'b10, 0, 0);
    set_m(1, 1, 32'h40, 32'h11111111, 1, 2'b10, 0, 1);
    gnt_log.delete();
    step();
    set_m(1, 1, 32'h44, 32'h22222222, 1, 2'b10, 0, 1);
    step();
    set_m(1, 1, 32'h48, 32'h33333333, 1, 2'b10, 0, 0);
    step();
    idle(1);
    step();
    idle(0);
    exp_seq = '{1, 1, 1, 0}; check_log("r43_lock");
    step();

    // Requester 0 locks; dropping req releases ownership, then 1 is served.
    set_m(0, 1, 32'h8, 32'h0, 0, 2'b10, 0, 1);
    gnt_log.delete();
    step();
    set_m(1, 1, 32'hC, 32'h0, 0, 2'b10, 0, 0);
    set_m(0, 1, 32'h4, 32'h0, 0, 2'b10, 0, 1);
    step();
    idle(0);
    step();
    step();
    idle(1);
    exp_seq = '{0, 0, 1}; check_log("own0_release");
    step();

    // Misaligned word store: no RAM write, error response.
    set_m(0, 1, 32'h06, 32'hAAAAAAAA, 1, 2'b10, 0, 0);
    #2;
    check("r44_mem_we", mem_we, 0);
    step();
    idle(0);
    check("r44_rvalid", m0_rvalid, 1);
    check("r44_err", m0_err, 1);
    check("r44_rdata", m0_rdata, 32'h0);
    check("r44_ram", ram[6], 8'hE3);
    step();

    // Byte store then sign-extended byte load.
    set_m(0, 1, 32'h3, 32'h00000080, 1, 2'b00, 0, 0);
    step();
    set_m(0, 1, 32'h3, 32'h0, 0, 2'b00, 1, 0);
    step();
    idle(0);
    check("r45_rdata", m0_rdata, 32'hFFFFFF80);
    check("r45_err", m0_err, 0);
    step();

    // Legality boundaries on requester 1.
    for (int i = 0; i < 7; i++) begin
      set_m(1, 1, bt_addr[i], 32'h0, 0, bt_size[i], 1, 0);
      step();
      check($sformatf("bound_err_%0d", i), m1_err, bt_err[i]);
    end
    idle(1);
    step();

    // Reset while requester 1 owns the RAM.
    set_m(1, 1, 32'h10, 32'h0, 0, 2'b10, 0, 1);
    step();
    check("r46_pre_rdata", m1_rdata, 32'hC49F7A55);
    rst_n = 1'b0;
    #1;
    check("r46_rvalid", m1_rvalid, 0);
    check("r46_rdata", m1_rdata, 32'h0);
    check("r46_gnt", {m1_gnt, m0_gnt}, 0);
    step();
    step();
    rst_n = 1'b1;
    set_m(0, 1, 32'h10, 32'h0, 0, 2'b10, 0, 0);
    set_m(1, 1, 32'h14, 32'h0, 0, 2'b10, 0, 0);
    gnt_log.delete();
    step();
    idle(0);
    exp_seq = '{0}; check_log("r46_first");
    step();
    idle(1);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
